// File: rtl/ex_stage_unit.sv
// Execute stage: one-hot ALU select, flag-based branch resolution and an
// iterative restoring divider for DIV/MOD, all behind a registered result.
module ex_stage_unit #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [21:0]       ctrl_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] immx,
  input  logic [DATA_W-1:0] st_data_in,
  input  logic [DATA_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_data_out,
  output logic [21:0]       ctrl_out,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc,
  output logic              flag_e,
  output logic              flag_gt,
  output logic              illegal
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, DIV} state_t;
  state_t state_reg, state_next;

  logic is_st, is_ld, is_beq, is_bgt, is_ret, is_imm, is_ubr, is_call;
  logic is_add, is_sub, is_cmp, is_mul, is_div, is_mod;
  logic is_lsl, is_lsr, is_asr, is_or, is_and, is_not, is_mov;

  assign is_st   = ctrl_in[0];
  assign is_ld   = ctrl_in[1];
  assign is_beq  = ctrl_in[2];
  assign is_bgt  = ctrl_in[3];
  assign is_ret  = ctrl_in[4];
  assign is_imm  = ctrl_in[5];
  assign is_ubr  = ctrl_in[7];
  assign is_call = ctrl_in[8];
  assign is_add  = ctrl_in[9];
  assign is_sub  = ctrl_in[10];
  assign is_cmp  = ctrl_in[11];
  assign is_mul  = ctrl_in[12];
  assign is_div  = ctrl_in[13];
  assign is_mod  = ctrl_in[14];
  assign is_lsl  = ctrl_in[15];
  assign is_lsr  = ctrl_in[16];
  assign is_asr  = ctrl_in[17];
  assign is_or   = ctrl_in[18];
  assign is_and  = ctrl_in[19];
  assign is_not  = ctrl_in[20];
  assign is_mov  = ctrl_in[21];

  logic [DATA_W-1:0] b_val;
  logic [4:0]        sh;
  logic [12:0]       alu_sel;
  logic              illegal_now;

  assign b_val   = is_imm ? immx : op_b;
  assign sh      = b_val[4:0];
  assign alu_sel = ctrl_in[21:9];
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign illegal_now = |(alu_sel & (alu_sel - 13'd1));

  logic [DATA_W-1:0] single_res;
  always_comb begin
    single_res = '0;
    if (illegal_now)                single_res = '0;
    else if (is_call)               single_res = pc_in + DATA_W'(4);
    else if (is_add | is_ld | is_st) single_res = op_a + b_val;
    else if (is_sub | is_cmp)       single_res = op_a - b_val;
    else if (is_mul)                single_res = op_a * b_val;
    else if (is_lsl)                single_res = op_a << sh;
    else if (is_lsr)                single_res = op_a >> sh;
    else if (is_asr)                single_res = $unsigned($signed(op_a) >>> sh);
    else if (is_or)                 single_res = op_a | b_val;
    else if (is_and)                single_res = op_a & b_val;
    else if (is_not)                single_res = ~b_val;
    else if (is_mov)                single_res = b_val;
  end

  logic              is_branch, taken_now;
  logic [DATA_W-1:0] bpc_now;

  // Flags are the registered values, so a preceding CMP is already visible.
  assign is_branch = is_beq | is_bgt | is_ubr | is_ret;
  assign taken_now = is_ubr | (is_beq & flag_e) | (is_bgt & flag_gt);
  assign bpc_now   = !is_branch ? '0 : (is_ret ? op_a : br_target);

  logic accept, is_divop, start_div, load_single, div_done;
  logic [CNT_W-1:0] cnt_reg;

  assign accept      = in_valid && in_ready;
  assign is_divop    = (is_div | is_mod) && !illegal_now;
  assign start_div   = accept && is_divop;
  assign load_single = accept && !is_divop;
  assign div_done    = (state_reg == DIV) && (cnt_reg == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && is_divop) state_next = DIV;
      end
      DIV: begin
        if (div_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [DATA_W-1:0] dividend_reg, rem_reg, quo_reg, dsor_reg;
  logic              a_neg_reg, q_neg_reg, dzero_reg, mod_reg;
  logic [21:0]       ctrl_hold_reg;
  logic [DATA_W-1:0] st_hold_reg, bpc_hold_reg;
  logic              bt_hold_reg;

  logic [DATA_W-1:0] a_mag, b_mag;
  assign a_mag = op_a[DATA_W-1] ? -op_a : op_a;
  assign b_mag = op_b[DATA_W-1] ? -op_b : op_b;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  logic [DATA_W:0]   rem_sh;
  logic              fits;
  logic [DATA_W-1:0] rem_step, quo_step;
  assign rem_sh   = {rem_reg, quo_reg[DATA_W-1]};
  assign fits     = rem_sh >= {1'b0, dsor_reg};
  assign rem_step = fits ? (rem_sh[DATA_W-1:0] - dsor_reg) : rem_sh[DATA_W-1:0];
  assign quo_step = {quo_reg[DATA_W-2:0], fits};

  logic [DATA_W-1:0] q_signed, r_signed, div_val;
  assign q_signed = q_neg_reg ? -quo_reg : quo_reg;
  assign r_signed = a_neg_reg ? -rem_reg : rem_reg;
  assign div_val  = mod_reg ? (dzero_reg ? dividend_reg : r_signed)
                            : (dzero_reg ? '1 : q_signed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend_reg  <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dsor_reg      <= '0;
      cnt_reg       <= '0;
      a_neg_reg     <= 1'b0;
      q_neg_reg     <= 1'b0;
      dzero_reg     <= 1'b0;
      mod_reg       <= 1'b0;
      ctrl_hold_reg <= '0;
      st_hold_reg   <= '0;
      bpc_hold_reg  <= '0;
      bt_hold_reg   <= 1'b0;
    end else if (start_div) begin
      dividend_reg  <= op_a;
      rem_reg       <= '0;
      quo_reg       <= a_mag;
      dsor_reg      <= b_mag;
      cnt_reg       <= '0;
      a_neg_reg     <= op_a[DATA_W-1];
      q_neg_reg     <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
      dzero_reg     <= (op_b == '0);
      mod_reg       <= is_mod;
      ctrl_hold_reg <= ctrl_in;
      st_hold_reg   <= st_data_in;
      bpc_hold_reg  <= bpc_now;
      bt_hold_reg   <= taken_now;
    end else if ((state_reg == DIV) && (cnt_reg != DIV_LAST)) begin
      rem_reg <= rem_step;
      quo_reg <= quo_step;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_e  <= 1'b0;
      flag_gt <= 1'b0;
    end else if (accept && is_cmp && !illegal_now) begin
      flag_e  <= (op_a == b_val);
      flag_gt <= ($signed(op_a) > $signed(b_val));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      alu_result   <= '0;
      st_data_out  <= '0;
      ctrl_out     <= '0;
      branch_taken <= 1'b0;
      branch_pc    <= '0;
      illegal      <= 1'b0;
    end else if (load_single) begin
      out_valid    <= 1'b1;
      alu_result   <= single_res;
      st_data_out  <= st_data_in;
      ctrl_out     <= ctrl_in;
      branch_taken <= is_branch & taken_now;
      branch_pc    <= bpc_now;
      illegal      <= illegal_now;
    end else if (div_done) begin
      out_valid    <= 1'b1;
      alu_result   <= div_val;
      st_data_out  <= st_hold_reg;
      ctrl_out     <= ctrl_hold_reg;
      branch_taken <= bt_hold_reg;
      branch_pc    <= bpc_hold_reg;
      illegal      <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Scoreboard bench for ex_stage_unit: expectations are queued at accept and
// compared when the stage hands a result downstream.
module tb_ex_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [21:0] ctrl_in, ctrl_out;
  logic [31:0] pc_in, op_a, op_b, immx, st_data_in, br_target;
  logic [31:0] alu_result, st_data_out, branch_pc;
  logic        branch_taken, flag_e, flag_gt, illegal;

  ex_stage_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .op_a(op_a), .op_b(op_b), .immx(immx),
    .st_data_in(st_data_in), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .st_data_out(st_data_out),
    .ctrl_out(ctrl_out), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .flag_e(flag_e), .flag_gt(flag_gt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] C_ST  = 22'(1 << 0);
  localparam logic [21:0] C_LD  = 22'(1 << 1);
  localparam logic [21:0] C_BEQ = 22'(1 << 2);
  localparam logic [21:0] C_BGT = 22'(1 << 3);
  localparam logic [21:0] C_RET = 22'(1 << 4);
  localparam logic [21:0] C_IMM = 22'(1 << 5);
  localparam logic [21:0] C_UBR = 22'(1 << 7);
  localparam logic [21:0] C_CAL = 22'(1 << 8);
  localparam logic [21:0] C_ADD = 22'(1 << 9);
  localparam logic [21:0] C_SUB = 22'(1 << 10);
  localparam logic [21:0] C_CMP = 22'(1 << 11);
  localparam logic [21:0] C_MUL = 22'(1 << 12);
  localparam logic [21:0] C_DIV = 22'(1 << 13);
  localparam logic [21:0] C_MOD = 22'(1 << 14);
  localparam logic [21:0] C_LSL = 22'(1 << 15);
  localparam logic [21:0] C_LSR = 22'(1 << 16);
  localparam logic [21:0] C_ASR = 22'(1 << 17);
  localparam logic [21:0] C_OR  = 22'(1 << 18);
  localparam logic [21:0] C_NOT = 22'(1 << 20);
  localparam logic [21:0] C_MOV = 22'(1 << 21);
  localparam logic [31:0] ST_MASK = 32'h5A5A_5A5A;
  localparam logic [31:0] NB      = 32'hDEAD_0000;

  typedef struct packed {
    logic [21:0] c;
    logic [31:0] a, b, imm, pc, br, res;
    logic        bt;
    logic [31:0] bpc;
    logic        ill;
  } op_t;

  op_t exp_q[$];
  op_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic op_t mk(logic [21:0] c, logic [31:0] a, logic [31:0] b,
                             logic [31:0] imm, logic [31:0] pc, logic [31:0] br,
                             logic [31:0] res, logic bt, logic [31:0] bpc, logic ill);
    op_t o;
    o.c = c; o.a = a; o.b = b; o.imm = imm; o.pc = pc; o.br = br;
    o.res = res; o.bt = bt; o.bpc = bpc; o.ill = ill;
    return o;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic issue(input op_t o, output int waited);
    waited = 0;
    ctrl_in = o.c; op_a = o.a; op_b = o.b; immx = o.imm; pc_in = o.pc;
    br_target = o.br; st_data_in = o.a ^ ST_MASK; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      check_val("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(o);
    $display("issue ctrl=%h a=%h b=%h imm=%h waited=%0d", o.c, o.a, o.b, o.imm, waited);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_output", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result ctrl=%h res=%h bt=%0b bpc=%h ill=%0b", ctrl_out, alu_result,
                 branch_taken, branch_pc, illegal);
        check_val("alu_result", alu_result, mon_e.res);
        check_val("ctrl_out", 32'(ctrl_out), 32'(mon_e.c));
        check_val("st_data_out", st_data_out, mon_e.a ^ ST_MASK);
        check_val("branch_taken", 32'(branch_taken), 32'(mon_e.bt));
        check_val("branch_pc", branch_pc, mon_e.bpc);
        check_val("illegal", 32'(illegal), 32'(mon_e.ill));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  op_t ops[11];
  op_t divs[7];
  int  w, lat, seen;

  initial begin
    ops[0]  = mk(C_ADD | C_IMM, 5, 0, 7, 0, NB, 12, 0, 0, 0);
    ops[1]  = mk(C_SUB, 10, 3, 0, 0, NB, 7, 0, 0, 0);
    ops[2]  = mk(C_MUL, 32'hFFFF_FFFF, 5, 0, 0, NB, 32'hFFFF_FFFB, 0, 0, 0);
    ops[3]  = mk(C_LSL, 1, 32'h24, 0, 0, NB, 32'h10, 0, 0, 0);
    ops[4]  = mk(C_LSR, 32'h8000_0000, 31, 0, 0, NB, 1, 0, 0, 0);
    ops[5]  = mk(C_ASR, 32'h8000_0000, 4, 0, 0, NB, 32'hF800_0000, 0, 0, 0);
    ops[6]  = mk(C_OR, 32'hF0, 32'h0F, 0, 0, NB, 32'hFF, 0, 0, 0);
    ops[7]  = mk(C_NOT, 0, 0, 0, 0, NB, 32'hFFFF_FFFF, 0, 0, 0);
    ops[8]  = mk(C_MOV | C_IMM, 0, 9, 32'h1234, 0, NB, 32'h1234, 0, 0, 0);
    ops[9]  = mk(C_LD | C_IMM, 32'h100, 0, 8, 0, NB, 32'h108, 0, 0, 0);
    ops[10] = mk(C_CAL | C_UBR, 0, 0, 0, 32'h1000, 32'h2000, 32'h1004, 1, 32'h2000, 0);

    divs[0] = mk(C_DIV, 32'hFFFF_FFF9, 2, 0, 0, NB, 32'hFFFF_FFFD, 0, 0, 0);
    divs[1] = mk(C_MOD, 32'hFFFF_FFF9, 2, 0, 0, NB, 32'hFFFF_FFFF, 0, 0, 0);
    divs[2] = mk(C_DIV, 32'hFFFF_FFF9, 0, 0, 0, NB, 32'hFFFF_FFFF, 0, 0, 0);
    divs[3] = mk(C_MOD, 32'hFFFF_FFF9, 0, 0, 0, NB, 32'hFFFF_FFF9, 0, 0, 0);
    divs[4] = mk(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, NB, 32'h8000_0000, 0, 0, 0);
    divs[5] = mk(C_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, NB, 0, 0, 0, 0);
    divs[6] = mk(C_DIV | C_ST, 100, 7, 0, 0, NB, 14, 0, 0, 0);

    reset = 1'b1; in_valid = 1'b0; ctrl_in = '0; pc_in = '0; op_a = '0; op_b = '0;
    immx = '0; st_data_in = '0; br_target = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_alu_result", alu_result, 0);
    check_val("rst_flags", {30'd0, flag_e, flag_gt}, 0);
    @(negedge clk) reset = 1'b0;
    #1 check_val("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Single-cycle ops back to back: every accept after the first must be immediate.
    for (int i = 0; i < 11; i++) begin
      issue(ops[i], w);
      if (i > 0) check_val("no_bubble", w, 0);
    end
    repeat (3) @(posedge clk); #1;

    issue(mk(C_CMP, 3, 3, 0, 0, NB, 0, 0, 0, 0), w);
    check_val("cmp_eq_flag_e", 32'(flag_e), 1);
    check_val("cmp_eq_flag_gt", 32'(flag_gt), 0);
    issue(mk(C_BEQ, 0, 0, 0, 0, 32'h40, 0, 1, 32'h40, 0), w);
    issue(mk(C_CMP | C_IMM, 32'hFFFF_FFFF, 0, 1, 0, NB, 32'hFFFF_FFFE, 0, 0, 0), w);
    check_val("cmp_neg_flag_e", 32'(flag_e), 0);
    check_val("cmp_neg_flag_gt", 32'(flag_gt), 0);
    issue(mk(C_BGT, 0, 0, 0, 0, 32'h80, 0, 0, 32'h80, 0), w);
    issue(mk(C_RET, 32'h100, 0, 0, 0, 32'h999, 0, 0, 32'h100, 0), w);
    issue(mk(C_ADD | C_SUB, 5, 3, 0, 0, NB, 0, 0, 0, 1), w);
    repeat (3) @(posedge clk); #1;

    // Output hold under backpressure, then drain and accept in the same cycle.
    out_ready = 1'b0;
    issue(mk(C_ADD | C_IMM, 5, 0, 7, 0, NB, 12, 0, 0, 0), w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(out_valid), 1);
      check_val("hold_result", alu_result, 12);
      check_val("hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(mk(C_SUB, 9, 4, 0, 0, NB, 5, 0, 0, 0), w);
    check_val("drain_accept_wait", w, 0);
    check_val("drain_accept_valid", 32'(out_valid), 1);
    repeat (3) @(posedge clk); #1;

    // Divider: exact latency on the first, then the remaining cases in sequence.
    issue(divs[0], w);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 5) check_val("div_busy_in_ready", 32'(in_ready), 0);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check_val("div_latency", lat, 33);
    for (int i = 1; i < 7; i++) issue(divs[i], w);
    repeat (40) @(posedge clk); #1;

    // Reset in the middle of a divide.
    issue(mk(C_CMP, 5, 2, 0, 0, NB, 3, 0, 0, 0), w);
    check_val("cmp_gt_flag", 32'(flag_gt), 1);
    issue(mk(C_DIV, 100, 7, 0, 0, NB, 14, 0, 0, 0), w);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort_out_valid", 32'(out_valid), 0);
    check_val("abort_alu_result", alu_result, 0);
    check_val("abort_flag_gt", 32'(flag_gt), 0);
    check_val("abort_ctrl_out", 32'(ctrl_out), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check_val("abort_in_ready", 32'(in_ready), 1);
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("abort_no_result", seen, 0);
    check_val("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
